sata_dout_pattern_checker: RTL and testbench

//  Drains the read side of the user_dout ping-pong FIFO from the sata_stack (hard drive -> user path).

---
 rtl/sata_dout_pattern_checker_pkg.sv | 24 ++
 rtl/sata_dout_pattern_checker_pattern_gen.sv | 39 +++
 rtl/sata_dout_pattern_checker.sv | 136 +++++++++++++
 tb/tb_sata_dout_pattern_checker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_dout_pattern_checker_pkg.sv
// Shared FSM encodings and pattern constants for the user_dout pattern checker.
// The LFSR helpers are only referenced when PATTERN_LFSR_EN is defined.
package sata_dout_pattern_checker_pkg;

    typedef enum logic [1:0] {
        PCHK_IDLE  = 2'd0,
        PCHK_CLAIM = 2'd1,
        PCHK_READ  = 2'd2,
        PCHK_DRAIN = 2'd3
    } pchk_state_t;

    localparam logic [31:0] PATTERN_LFSR_POLY = 32'h80200003;

    // LSB set: fold in the polynomial (which also clears the LSB); otherwise shift right.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? (v ^ PATTERN_LFSR_POLY) : (v >> 1);
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == '0) ? 32'h0000_0001 : s;
    endfunction

endpackage

// File: rtl/sata_dout_pattern_checker_pattern_gen.sv
// Expected-word source shared by the read-path checker and the write-path source.
// Incrementing counter by default; 32-bit Galois LFSR when PATTERN_LFSR_EN is defined.
module sata_pattern_gen
    import sata_dout_pattern_checker_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        advance,
    output logic [31:0] value
);

`ifdef PATTERN_LFSR_EN
    localparam logic [31:0] START = lfsr_seed(SEED);
`else
    localparam logic [31:0] START = SEED;
`endif

    logic [31:0] next_value;

    always_comb begin
`ifdef PATTERN_LFSR_EN
        next_value = lfsr_step(value);
`else
        next_value = value + 32'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            value <= START;
        end else if (advance) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/sata_dout_pattern_checker.sv
// Sink for read tests: drains user_dout FIFO blocks and checks each word against a local pattern.
// Define PATTERN_LFSR_EN to switch the expected sequence from a counter to an LFSR.
module sata_dout_pattern_checker
    import sata_dout_pattern_checker_pkg::*;
#(
    parameter logic [31:0] SEED         = 32'h0000_0000,
    parameter int unsigned DATA_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic        ready,
    output logic        activate,
    input  logic [23:0] size,
    input  logic [31:0] data,
    output logic        strobe,
    output logic        busy,
    output logic [31:0] word_count,
    output logic [15:0] error_count,
    output logic        error,
    output logic [31:0] first_err_index,
    output logic [31:0] first_err_expected,
    output logic [31:0] first_err_actual
);

    pchk_state_t state, state_next;
    logic [23:0] blk_size;
    logic [23:0] cnt;
    logic        skip;
    logic        cmp_strobe;
    logic        cmp_valid;
    logic        mismatch;
    logic [31:0] expected;

    generate
        if (DATA_LATENCY == 0) begin : g_lat0
            assign cmp_strobe = strobe;
        end else begin : g_lat1
            logic strobe_d;
            always_ff @(posedge clk) begin
                if (!rst) strobe_d <= 1'b0;
                else      strobe_d <= strobe;
            end
            assign cmp_strobe = strobe_d;
        end
    endgenerate

    // Words of a block interrupted by clear are still drained but never scored.
    assign cmp_valid = cmp_strobe && !skip && !clear;
    assign mismatch  = (data != expected);

    sata_pattern_gen #(
        .SEED(SEED)
    ) u_pattern_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .advance(cmp_valid),
        .value  (expected)
    );

    always_comb begin
        state_next = state;
        strobe     = 1'b0;
        busy       = 1'b1;
        case (state)
            PCHK_IDLE: begin
                busy = 1'b0;
                if (enable && ready && !activate) state_next = PCHK_CLAIM;
            end
            PCHK_CLAIM: state_next = (size == '0) ? PCHK_DRAIN : PCHK_READ;
            PCHK_READ: begin
                // With at most one cycle of data latency the final compare lands in this same cycle.
                if (cnt < blk_size) strobe = 1'b1;
                else                state_next = PCHK_DRAIN;
            end
            PCHK_DRAIN: state_next = PCHK_IDLE;
            default:    state_next = PCHK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= PCHK_IDLE;
            activate <= 1'b0;
            blk_size <= '0;
            cnt      <= '0;
        end else begin
            state <= state_next;
            case (state)
                PCHK_CLAIM: begin
                    activate <= 1'b1;
                    blk_size <= size;
                    cnt      <= '0;
                end
                PCHK_READ:  if (strobe) cnt <= cnt + 24'd1;
                PCHK_DRAIN: activate <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            skip <= 1'b0;
        end else if (state_next == PCHK_IDLE) begin
            skip <= 1'b0;
        end else if (clear && busy) begin
            skip <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            word_count         <= '0;
            error_count        <= '0;
            error              <= 1'b0;
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_actual   <= '0;
        end else if (cmp_valid) begin
            word_count <= word_count + 32'd1;
            if (mismatch) begin
                if (error_count != '1) error_count <= error_count + 16'd1;
                error <= 1'b1;
                if (!error) begin
                    first_err_index    <= word_count;
                    first_err_expected <= expected;
                    first_err_actual   <= data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sata_dout_pattern_checker.sv
// Self-checking bench for sata_dout_pattern_checker with a small read-FIFO model.
// Builds with or without PATTERN_LFSR_EN; each build exercises its own expected sequence.
`timescale 1ns/1ps
module tb_sata_dout_pattern_checker;

`ifdef PATTERN_LFSR_EN
    localparam logic [31:0] TB_SEED = 32'h0000_0001;
`else
    localparam logic [31:0] TB_SEED = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    logic [23:0] size = '0;
    logic [31:0] data = '0;
    logic        activate, strobe, busy, error;
    logic [31:0] word_count, first_err_index, first_err_expected, first_err_actual;
    logic [15:0] error_count;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] fifo[$];
    logic [31:0] src_pat = TB_SEED;

    typedef struct {
        bit          clr;
        int          n;
        int          bad_idx;
        logic [31:0] bad_val;
        int          act;
        int          strb;
        logic [31:0] wc;
        logic [15:0] ec;
        logic        err;
        logic [31:0] fi;
        logic [31:0] fe;
        logic [31:0] fa;
    } vec_t;

    vec_t tbl[6];
    vec_t sb[$];

    sata_dout_pattern_checker #(
        .SEED(TB_SEED),
        .DATA_LATENCY(1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .clear             (clear),
        .ready             (ready),
        .activate          (activate),
        .size              (size),
        .data              (data),
        .strobe            (strobe),
        .busy              (busy),
        .word_count        (word_count),
        .error_count       (error_count),
        .error             (error),
        .first_err_index   (first_err_index),
        .first_err_expected(first_err_expected),
        .first_err_actual  (first_err_actual)
    );

    always #5 clk = ~clk;

    // Read FIFO: data for a strobe appears one cycle later.
    always @(posedge clk) begin
        if (!rst) begin
            data <= '0;
            fifo.delete();
        end else if (strobe) begin
            if (fifo.size() != 0) data <= fifo.pop_front();
            else                  data <= 32'hBAD0_0000;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_pattern(input int n, input int bad_idx, input logic [31:0] bad_val);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = (i == bad_idx) ? bad_val : src_pat;
            fifo.push_back(w);
            src_pat = src_pat + 32'd1;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        src_pat = TB_SEED;
    endtask

    // Offers one block; clear_at >= 0 pulses clear in the cycle that strobes that word.
    task automatic run_block(input int n, input int clear_at,
                             output int act_cyc, output int strb_cyc, output int lat);
        int cyc;
        bit seen_busy;
        bit done;
        act_cyc = 0; strb_cyc = 0; lat = -1; cyc = 0; seen_busy = 0; done = 0;
        @(negedge clk);
        size = 24'(n); ready = 1'b1; enable = 1'b1;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            cyc++;
            clear = 1'b0;
            if (activate) begin
                act_cyc++;
                ready = 1'b0;
                enable = 1'b0;
            end
            if (strobe) begin
                if (lat < 0) lat = cyc;
                if (strb_cyc == clear_at) clear = 1'b1;
                strb_cyc++;
            end
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) done = 1'b1;
        end
        clear = 1'b0;
        ready = 1'b0;
        enable = 1'b0;
        check("block_completes", {31'b0, done}, 32'd1);
    endtask

    initial begin
        int act, strb, lat;
        vec_t e;

        tbl[0] = '{0, 16, -1, 32'h0,        18, 16, 32'd16, 16'd0, 1'b0, 32'd0, 32'd0, 32'h0};
        tbl[1] = '{1,  8,  5, 32'hDEADBEEF, 10,  8, 32'd8,  16'd1, 1'b1, 32'd5, 32'd5, 32'hDEADBEEF};
        tbl[2] = '{0,  0, -1, 32'h0,         1,  0, 32'd8,  16'd1, 1'b1, 32'd5, 32'd5, 32'hDEADBEEF};
        tbl[3] = '{0,  4,  1, 32'h0,         6,  4, 32'd12, 16'd2, 1'b1, 32'd5, 32'd5, 32'hDEADBEEF};
        tbl[4] = '{1,  3, -1, 32'h0,         5,  3, 32'd3,  16'd0, 1'b0, 32'd0, 32'd0, 32'h0};
        tbl[5] = '{0,  1,  0, 32'hFFFFFFFF,  3,  1, 32'd4,  16'd1, 1'b1, 32'd3, 32'd3, 32'hFFFFFFFF};

        // Reset with a block offered: nothing may be claimed.
        ready = 1'b1; enable = 1'b1; size = 24'd4;
        repeat (3) @(negedge clk);
        check("rst.activate", {31'b0, activate}, 32'd0);
        check("rst.strobe", {31'b0, strobe}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.word_count", word_count, 32'd0);
        check("rst.error_count", {16'b0, error_count}, 32'd0);
        check("rst.error", {31'b0, error}, 32'd0);
        check("rst.first_err_index", first_err_index, 32'd0);
        check("rst.first_err_expected", first_err_expected, 32'd0);
        check("rst.first_err_actual", first_err_actual, 32'd0);
        ready = 1'b0; enable = 1'b0; size = '0;
        rst = 1'b1;
        @(negedge clk);

`ifdef PATTERN_LFSR_EN
        fifo.push_back(32'h0000_0001);
        fifo.push_back(32'h8020_0002);
        fifo.push_back(32'h4010_0001);
        run_block(3, -1, act, strb, lat);
        check("lfsr.word_count", word_count, 32'd3);
        check("lfsr.error_count", {16'b0, error_count}, 32'd0);
        check("lfsr.error", {31'b0, error}, 32'd0);
        do_clear();
        fifo.push_back(32'h0000_0001);
        fifo.push_back(32'h8020_0002);
        fifo.push_back(32'h4010_0000);
        run_block(3, -1, act, strb, lat);
        check("lfsr_bad.error_count", {16'b0, error_count}, 32'd1);
        check("lfsr_bad.first_err_index", first_err_index, 32'd2);
        check("lfsr_bad.first_err_expected", first_err_expected, 32'h4010_0001);
        check("lfsr_bad.first_err_actual", first_err_actual, 32'h4010_0000);
`else
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr) do_clear();
            push_pattern(tbl[i].n, tbl[i].bad_idx, tbl[i].bad_val);
            sb.push_back(tbl[i]);
            run_block(tbl[i].n, -1, act, strb, lat);
            e = sb.pop_front();
            check($sformatf("v%0d.activate_cycles", i), 32'(act), 32'(e.act));
            check($sformatf("v%0d.strobes", i), 32'(strb), 32'(e.strb));
            check($sformatf("v%0d.word_count", i), word_count, e.wc);
            check($sformatf("v%0d.error_count", i), {16'b0, error_count}, {16'b0, e.ec});
            check($sformatf("v%0d.error", i), {31'b0, error}, {31'b0, e.err});
            check($sformatf("v%0d.first_err_index", i), first_err_index, e.fi);
            check($sformatf("v%0d.first_err_expected", i), first_err_expected, e.fe);
            check($sformatf("v%0d.first_err_actual", i), first_err_actual, e.fa);
            if (e.n > 0) check($sformatf("v%0d.first_strobe_latency", i), 32'(lat), 32'd2);
        end

        // Two 512-word blocks with ready held high; enable drops once the second is claimed.
        begin
            int rises, gap, phase, strobes;
            bit prev_act;
            rises = 0; gap = 0; phase = 0; strobes = 0; prev_act = 1'b0;
            do_clear();
            push_pattern(1024, -1, 32'h0);
            @(negedge clk);
            size = 24'd512; ready = 1'b1; enable = 1'b1;
            for (int t = 0; t < 1200; t++) begin
                @(negedge clk);
                if (activate && !prev_act) begin
                    rises++;
                    if (rises == 2) enable = 1'b0;
                end
                prev_act = activate;
                if (strobe) strobes++;
                case (phase)
                    0: if (busy) phase = 1;
                    1: if (!busy) begin phase = 2; gap = 1; end
                    2: if (busy) phase = 3; else gap++;
                    3: if (!busy) phase = 4;
                    default: ;
                endcase
            end
            ready = 1'b0;
            check("b2b.blocks_done", 32'(phase), 32'd4);
            check("b2b.claims", 32'(rises), 32'd2);
            check("b2b.idle_gap", 32'(gap), 32'd1);
            check("b2b.strobes", 32'(strobes), 32'd1024);
            check("b2b.word_count", word_count, 32'd1024);
            check("b2b.error_count", {16'b0, error_count}, 32'd0);
        end

        // clear at word 3 of 10, words 2..9 corrupted: the block drains unscored.
        do_clear();
        for (int i = 0; i < 10; i++) fifo.push_back((i >= 2) ? (32'(i) ^ 32'hFFFF_0000) : 32'(i));
        run_block(10, 3, act, strb, lat);
        check("clr_mid.strobes", 32'(strb), 32'd10);
        check("clr_mid.word_count", word_count, 32'd0);
        check("clr_mid.error_count", {16'b0, error_count}, 32'd0);
        check("clr_mid.error", {31'b0, error}, 32'd0);
        check("clr_mid.first_err_actual", first_err_actual, 32'd0);
        src_pat = TB_SEED;
        push_pattern(4, -1, 32'h0);
        run_block(4, -1, act, strb, lat);
        check("clr_next.word_count", word_count, 32'd4);
        check("clr_next.error", {31'b0, error}, 32'd0);

        // Reset in the middle of a block.
        push_pattern(20, -1, 32'h0);
        @(negedge clk);
        size = 24'd20; ready = 1'b1; enable = 1'b1;
        strb = 0;
        for (int t = 0; t < 100 && strb < 5; t++) begin
            @(negedge clk);
            if (strobe) strb++;
        end
        rst = 1'b0; ready = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("rst_mid.activate", {31'b0, activate}, 32'd0);
        check("rst_mid.busy", {31'b0, busy}, 32'd0);
        check("rst_mid.word_count", word_count, 32'd0);
        rst = 1'b1;
        src_pat = TB_SEED;
        @(negedge clk);
        push_pattern(2, -1, 32'h0);
        run_block(2, -1, act, strb, lat);
        check("rst_after.word_count", word_count, 32'd2);
        check("rst_after.error", {31'b0, error}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
